// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction-fetch front end
package ifetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - circular buffer of fetched {pc, instr} pairs feeding decode
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  fetch_entry_t  mem [DEPTH];
  logic          do_pop;

  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage is cleared on reset so the head outputs are never X; a flush only rewinds pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch PC, instruction-memory handshake and redirect handling
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
);

  localparam int             CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pending_pc;
  logic [31:0]   redirect_tgt;
  logic          push;
  logic          pop;
  logic          empty;
  logic [CW-1:0] count;
  fetch_entry_t  push_data;
  fetch_entry_t  head;

  always_comb begin
    redirect_tgt    = align_pc(redirect_pc);
    push            = (state == REQ) && imem_ack && !redirect_valid;
    pop             = if_valid && if_ready;
    push_data.pc    = imem_addr;
    push_data.instr = imem_rdata;
  end

  assign if_valid = !empty;
  assign if_pc    = head.pc;
  assign if_instr = head.instr;

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head),
    .empty     (empty),
    .count     (count)
  );

  // A request cannot be withdrawn once issued, so a redirect that arrives before the
  // ack parks its target in pending_pc and the returning data is dropped in DROP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      pending_pc <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
          end else if (count < FULL) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
            fetch_pc <= redirect_valid ? redirect_tgt : imem_addr + PC_STEP;
          end else if (redirect_valid) begin
            pending_pc <= redirect_tgt;
            state      <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
            fetch_pc <= redirect_valid ? redirect_tgt : pending_pc;
          end else if (redirect_valid) begin
            pending_pc <= redirect_tgt;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit with a budgeted memory model
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model: acks after mem_delay wait cycles, at most ack_limit acks since reset.
  int   mem_delay = 0;
  int   ack_limit = 0;
  int   ack_count = 0;
  int   wait_cnt  = 0;
  logic force_ack = 1'b0;
  int   cyc       = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_instr[$];
  int          rise_cycles[$];

  logic        prev_req  = 1'b0;
  logic [31:0] prev_addr = '0;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack   = force_ack | (imem_req && (wait_cnt >= mem_delay) && (ack_count < ack_limit));
  assign imem_rdata = 32'h2000_0000 + imem_addr;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
    if (rst) ack_count <= 0;
    else if (imem_req && imem_ack) ack_count <= ack_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((exp_addr.size() != 0 || exp_pc.size() != 0) && k < budget) begin
      step(1);
      k++;
    end
    n_tests++;
    if (exp_addr.size() != 0 || exp_pc.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d requests and %0d outputs still expected after %0d cycles",
               name, exp_addr.size(), exp_pc.size(), budget);
    end
  endtask

  task automatic exp_out(input logic [31:0] pc, input logic [31:0] instr);
    exp_pc.push_back(pc);
    exp_instr.push_back(instr);
  endtask

  // Monitor: new requests, request stability and decode handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && !prev_req) begin
        rise_cycles.push_back(cyc);
        if (exp_addr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_request: got addr %h expected none", imem_addr);
        end else begin
          check("req_addr", imem_addr, exp_addr.pop_front());
        end
      end
      if (imem_req && prev_req) check("addr_stable", imem_addr, prev_addr);
      if (if_valid && if_ready) begin
        if (exp_pc.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got pc %h instr %h expected none", if_pc, if_instr);
        end else begin
          check("out_pc", if_pc, exp_pc.pop_front());
          check("out_instr", if_instr, exp_instr.pop_front());
        end
      end
    end
    prev_req  = imem_req;
    prev_addr = imem_addr;
  end

  initial begin
    int k;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    mem_delay      = 0;
    ack_limit      = 4;
    step(2);

    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_pc",    if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);

    // Streaming with zero-wait memory; fifth request stalls on the ack budget.
    rise_cycles.delete();
    foreach (exp_addr[i]) exp_addr.delete();
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    exp_addr.push_back(32'hC);
    exp_addr.push_back(32'h10);
    exp_out(32'h0, 32'h2000_0000);
    exp_out(32'h4, 32'h2000_0004);
    exp_out(32'h8, 32'h2000_0008);
    exp_out(32'hC, 32'h2000_000C);
    rst = 1'b0;
    wait_drain("t1_drain", 60);
    step(2);
    check("t1_rises", 32'(rise_cycles.size()), 32'd5);
    for (int i = 1; i < rise_cycles.size(); i++)
      check("t1_spacing", 32'(rise_cycles[i] - rise_cycles[i-1]), 32'd2);
    check("t1_stall_req",  {31'd0, imem_req}, 32'd1);
    check("t1_stall_addr", imem_addr, 32'h10);
    check("t1_empty",      {31'd0, if_valid}, 32'd0);

    // Backpressure: exactly two entries fetched, then fetch resumes at 8 after draining.
    rst = 1'b1; if_ready = 1'b0; ack_limit = 2;
    step(2);
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    rst = 1'b0;
    step(15);
    check("t2_pending_reqs", 32'(exp_addr.size()), 32'd1);
    check("t2_req_idle",     {31'd0, imem_req}, 32'd0);
    check("t2_valid",        {31'd0, if_valid}, 32'd1);
    check("t2_head_pc",      if_pc, 32'h0);
    check("t2_head_instr",   if_instr, 32'h2000_0000);
    exp_out(32'h0, 32'h2000_0000);
    exp_out(32'h4, 32'h2000_0004);
    if_ready = 1'b1;
    wait_drain("t2_drain", 20);
    step(1);
    check("t2_resume_addr", imem_addr, 32'h8);

    // Slow memory with a redirect in the second wait cycle: data dropped, refetch at 0x100.
    rst = 1'b1; mem_delay = 3; ack_limit = 1;
    step(2);
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h100);
    rst = 1'b0;
    k = 0;
    while (!imem_req && k < 10) begin step(1); k++; end
    check("t3_req_up", {31'd0, imem_req}, 32'd1);
    step(1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step(1);
    redirect_valid = 1'b0;
    check("t3_addr_held", imem_addr, 32'h0);
    check("t3_no_valid",  {31'd0, if_valid}, 32'd0);
    wait_drain("t3_drain", 30);
    step(3);
    check("t3_addr",     imem_addr, 32'h100);
    check("t3_dropped",  {31'd0, if_valid}, 32'd0);
    ack_limit = 2;
    exp_addr.push_back(32'h104);
    exp_out(32'h100, 32'h2000_0100);
    wait_drain("t3_refetch", 30);

    // Redirect on the ack cycle with one entry buffered and decode ready.
    rst = 1'b1; mem_delay = 0; ack_limit = 1; if_ready = 1'b0;
    step(2);
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    rst = 1'b0;
    wait_drain("t4_fill", 20);
    step(2);
    check("t4_one_entry", {31'd0, if_valid}, 32'd1);
    check("t4_stall",     imem_addr, 32'h4);
    if_ready = 1'b1; ack_limit = 2; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    exp_out(32'h0, 32'h2000_0000);
    exp_addr.push_back(32'h200);
    step(1);
    redirect_valid = 1'b0;
    check("t4_flushed", {31'd0, if_valid}, 32'd0);
    wait_drain("t4_drain", 20);
    step(1);
    check("t4_target", imem_addr, 32'h200);
    check("t4_no_push", {31'd0, if_valid}, 32'd0);

    // Redirect to the top word (low bits ignored) and wrap to zero.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step(1);
    redirect_valid = 1'b0;
    ack_limit = 5;
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_out(32'hFFFF_FFFC, 32'h1FFF_FFFC);
    exp_out(32'h0, 32'h2000_0000);
    wait_drain("t5_wrap", 40);
    step(1);
    check("t5_stall_addr", imem_addr, 32'h4);

    // Reset mid-request with a late ack that must be ignored.
    rst = 1'b1; ack_limit = 0; force_ack = 1'b1;
    step(1);
    check("t6_req",   {31'd0, imem_req}, 32'd0);
    check("t6_valid", {31'd0, if_valid}, 32'd0);
    check("t6_addr",  imem_addr, 32'h0);
    rst = 1'b0;
    exp_addr.push_back(32'h0);
    step(1);
    force_ack = 1'b0;
    step(3);
    check("t6_restart_req",  {31'd0, imem_req}, 32'd1);
    check("t6_restart_addr", imem_addr, 32'h0);
    check("t6_no_data",      {31'd0, if_valid}, 32'd0);
    check("t6_req_seen",     32'(exp_addr.size()), 32'd0);
    check("t6_no_out_left",  32'(exp_pc.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
